// File: rtl/order_matcher.sv
// Order matcher: queues bids and asks from the slow-clock generator in two FIFOs and trades their heads while they cross.
// Optional spread accumulator output pnl is built only when ORDER_MATCHER_PNL_EN is defined.
module order_matcher #(
    parameter int DEPTH = 4,
    parameter int PW    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      order_tick,
    input  logic [PW-1:0]             buy_price,
    input  logic [PW-1:0]             sell_price,
    output logic                      trade_valid,
    output logic [PW-1:0]             trade_price,
    output logic [15:0]               trade_count,
    output logic [7:0]                drop_count,
    output logic [$clog2(DEPTH):0]    bid_depth,
    output logic [$clog2(DEPTH):0]    ask_depth,
`ifdef ORDER_MATCHER_PNL_EN
    output logic signed [17:0]        pnl,
`endif
    output logic                      busy
);

    // state   | meaning
    // IDLE    | waiting for a tick (or a pending one)
    // PUSH    | writing the new bid/ask into the FIFOs
    // COMPARE | checking whether the heads cross
    // TRADE   | trade pulse cycle; heads already popped

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   ONE_CNT  = 1;
    localparam logic [AW-1:0] ONE_PTR  = 1;

    typedef enum logic [1:0] {IDLE, PUSH, COMPARE, TRADE} state_t;

    state_t        state;
    logic          pending;
    logic          tick_s1, tick_s2, tick_s3, tick_rise;

    logic [PW-1:0] bid_mem [DEPTH];
    logic [PW-1:0] ask_mem [DEPTH];
    logic [AW-1:0] bid_rd, bid_wr, ask_rd, ask_wr;

    logic [PW-1:0] bid_head, ask_head;
    logic          bid_full, ask_full, crossing;
    logic [1:0]    drop_inc;
    logic [8:0]    drop_sum;

    assign bid_head = bid_mem[bid_rd];
    assign ask_head = ask_mem[ask_rd];
    assign bid_full = (bid_depth == FULL_CNT);
    assign ask_full = (ask_depth == FULL_CNT);
    assign crossing = (bid_depth != '0) && (ask_depth != '0) && (bid_head >= ask_head);
    assign drop_inc = {1'b0, bid_full} + {1'b0, ask_full};
    assign drop_sum = {1'b0, drop_count} + {7'b0, drop_inc};
    assign busy     = (state != IDLE);

`ifdef ORDER_MATCHER_PNL_EN
    logic [PW-1:0] spread;
    logic [18:0]   pnl_sum;
    // bid_head >= ask_head whenever this is used, so the difference is non-negative
    assign spread  = bid_head - ask_head;
    assign pnl_sum = {1'b0, pnl} + 19'(spread);
`endif

    // storage needs no reset: occupancy counters define validity
    always_ff @(posedge clk) begin
        if (state == PUSH) begin
            bid_mem[bid_wr] <= buy_price;
            ask_mem[ask_wr] <= sell_price;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_s1     <= 1'b0;
            tick_s2     <= 1'b0;
            tick_s3     <= 1'b0;
            tick_rise   <= 1'b0;
            state       <= IDLE;
            pending     <= 1'b0;
            bid_rd      <= '0;
            bid_wr      <= '0;
            ask_rd      <= '0;
            ask_wr      <= '0;
            bid_depth   <= '0;
            ask_depth   <= '0;
            trade_valid <= 1'b0;
            trade_price <= '0;
            trade_count <= '0;
            drop_count  <= '0;
`ifdef ORDER_MATCHER_PNL_EN
            pnl         <= '0;
`endif
        end else begin
            tick_s1     <= order_tick;
            tick_s2     <= tick_s1;
            tick_s3     <= tick_s2;
            tick_rise   <= tick_s2 & ~tick_s3;
            trade_valid <= 1'b0;

            if (state != IDLE && tick_rise)
                pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (tick_rise || pending) begin
                        pending <= 1'b0;
                        state   <= PUSH;
                    end
                end
                PUSH: begin
                    bid_wr <= bid_wr + ONE_PTR;
                    ask_wr <= ask_wr + ONE_PTR;
                    // full FIFO: drop the oldest entry so occupancy holds at DEPTH
                    if (bid_full) bid_rd <= bid_rd + ONE_PTR;
                    else          bid_depth <= bid_depth + ONE_CNT;
                    if (ask_full) ask_rd <= ask_rd + ONE_PTR;
                    else          ask_depth <= ask_depth + ONE_CNT;
                    drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
                    state      <= COMPARE;
                end
                COMPARE: begin
                    if (crossing) begin
                        trade_valid <= 1'b1;
                        trade_price <= ask_head;
                        bid_rd      <= bid_rd + ONE_PTR;
                        ask_rd      <= ask_rd + ONE_PTR;
                        bid_depth   <= bid_depth - ONE_CNT;
                        ask_depth   <= ask_depth - ONE_CNT;
                        if (trade_count != 16'hFFFF)
                            trade_count <= trade_count + 16'd1;
`ifdef ORDER_MATCHER_PNL_EN
                        pnl <= (pnl_sum[18:17] != 2'b00) ? 18'sd131071 : signed'(pnl_sum[17:0]);
`endif
                        state <= TRADE;
                    end else begin
                        state <= IDLE;
                    end
                end
                TRADE: begin
                    state <= COMPARE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_order_matcher.sv
// Directed self-checking bench for order_matcher (DEPTH=4, PW=8).
module tb_order_matcher;

    localparam int DEPTH = 4;
    localparam int PW    = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          order_tick = 1'b0;
    logic [PW-1:0] buy_price = '0;
    logic [PW-1:0] sell_price = '0;
    logic          trade_valid;
    logic [PW-1:0] trade_price;
    logic [15:0]   trade_count;
    logic [7:0]    drop_count;
    logic [2:0]    bid_depth, ask_depth;
    logic          busy;
`ifdef ORDER_MATCHER_PNL_EN
    logic signed [17:0] pnl;
`endif

    order_matcher #(.DEPTH(DEPTH), .PW(PW)) dut (
        .clk         (clk),
        .reset       (reset),
        .order_tick  (order_tick),
        .buy_price   (buy_price),
        .sell_price  (sell_price),
        .trade_valid (trade_valid),
        .trade_price (trade_price),
        .trade_count (trade_count),
        .drop_count  (drop_count),
        .bid_depth   (bid_depth),
        .ask_depth   (ask_depth),
`ifdef ORDER_MATCHER_PNL_EN
        .pnl         (pnl),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int consec = 0;
    logic prev_tv = 1'b0;
    logic [PW-1:0] tq[$];
    int tcyc[$];

    always @(negedge clk) begin
        cyc++;
        if (trade_valid) begin
            tq.push_back(trade_price);
            tcyc.push_back(cyc);
            if (prev_tv) consec++;
        end
        prev_tv = trade_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        order_tick = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic tick(input logic [PW-1:0] b, input logic [PW-1:0] s);
        @(negedge clk);
        buy_price  = b;
        sell_price = s;
        order_tick = 1'b1;
        repeat (2) @(negedge clk);
        order_tick = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int first;
        int n0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_trade_valid", 32'(trade_valid), 0);
        check("rst_trade_price", 32'(trade_price), 0);
        check("rst_trade_count", 32'(trade_count), 0);
        check("rst_drop_count",  32'(drop_count), 0);
        check("rst_bid_depth",   32'(bid_depth), 0);
        check("rst_ask_depth",   32'(ask_depth), 0);
        check("rst_busy",        32'(busy), 0);
`ifdef ORDER_MATCHER_PNL_EN
        check("rst_pnl",         32'(pnl), 0);
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // first trade: edge -> tick_rise 3 clks -> trade 3 clks later
        first = -1;
        buy_price  = 8'd70;
        sell_price = 8'd60;
        order_tick = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 2) order_tick = 1'b0;
            if (trade_valid && first < 0) first = k;
        end
        check("t1_latency",     32'(first), 6);
        check("t1_trade_price", 32'(trade_price), 60);
        check("t1_trade_count", 32'(trade_count), 1);
        check("t1_bid_depth",   32'(bid_depth), 0);
        check("t1_ask_depth",   32'(ask_depth), 0);
`ifdef ORDER_MATCHER_PNL_EN
        check("t1_pnl",         32'(pnl), 10);
`endif

        // non-crossing heads block
        n0 = tq.size();
        tick(8'd50, 8'd60);
        check("t2a_no_trade",   32'(tq.size()), 32'(n0));
        check("t2a_bid_depth",  32'(bid_depth), 1);
        check("t2a_ask_depth",  32'(ask_depth), 1);
        tick(8'd65, 8'd80);
        check("t2b_no_trade",   32'(tq.size()), 32'(n0));
        check("t2b_bid_depth",  32'(bid_depth), 2);
        check("t2b_ask_depth",  32'(ask_depth), 2);
        check("t2b_busy",       32'(busy), 0);

        // overflow: oldest entries dropped, one per FIFO
        do_reset();
        for (int i = 0; i < 4; i++) tick(8'd50, 8'd86);
        check("t3_bid_depth4",  32'(bid_depth), 4);
        check("t3_ask_depth4",  32'(ask_depth), 4);
        check("t3_drop4",       32'(drop_count), 0);
        tick(8'd50, 8'd86);
        check("t3_bid_depth5",  32'(bid_depth), 4);
        check("t3_ask_depth5",  32'(ask_depth), 4);
        check("t3_drop5",       32'(drop_count), 2);
        check("t3_trade_count", 32'(trade_count), 0);

        // blocker head dropped by overflow releases a chain of crossing heads
        do_reset();
        n0 = tq.size();
        tick(8'd10, 8'd200);
        tick(8'd60, 8'd55);
        tick(8'd70, 8'd58);
        tick(8'd75, 8'd57);
        check("t4_blocked",     32'(tq.size()), 32'(n0));
        check("t4_depth_full",  32'(bid_depth), 4);
        tick(8'd0, 8'd255);
        check("t4_ntrades",     32'(tq.size()), 32'(n0 + 3));
        if (tq.size() == n0 + 3) begin
            check("t4_price0",  32'(tq[n0]), 55);
            check("t4_price1",  32'(tq[n0 + 1]), 58);
            check("t4_price2",  32'(tq[n0 + 2]), 57);
            check("t4_gap01",   32'(tcyc[n0 + 1] - tcyc[n0]), 2);
            check("t4_gap12",   32'(tcyc[n0 + 2] - tcyc[n0 + 1]), 2);
        end
        check("t4_trade_count", 32'(trade_count), 3);
        check("t4_bid_depth",   32'(bid_depth), 1);
        check("t4_ask_depth",   32'(ask_depth), 1);
        check("t4_drop",        32'(drop_count), 2);
`ifdef ORDER_MATCHER_PNL_EN
        check("t4_pnl",         32'(pnl), 35);
`endif

        // equal prices cross
        do_reset();
        tick(8'd60, 8'd60);
        check("eq_trade_count", 32'(trade_count), 1);
        check("eq_trade_price", 32'(trade_price), 60);
        check("eq_bid_depth",   32'(bid_depth), 0);

        // second edge while busy -> pending; third edge while pending -> merged
        do_reset();
        @(negedge clk);
        buy_price  = 8'd70;
        sell_price = 8'd60;
        order_tick = 1'b1;
        @(negedge clk); order_tick = 1'b0;
        @(negedge clk); order_tick = 1'b1;
        @(negedge clk); order_tick = 1'b0;
        @(negedge clk); order_tick = 1'b1;
        @(negedge clk); order_tick = 1'b0;
        repeat (30) @(negedge clk);
        check("pend_trade_count", 32'(trade_count), 2);
        check("pend_bid_depth",   32'(bid_depth), 0);
        check("pend_drop",        32'(drop_count), 0);

        check("no_consecutive_trades", 32'(consec), 0);

        // reset asserted during TRADE
        do_reset();
        first = -1;
        buy_price  = 8'd70;
        sell_price = 8'd60;
        order_tick = 1'b1;
        for (int k = 1; k <= 20 && first < 0; k++) begin
            @(negedge clk);
            if (k == 2) order_tick = 1'b0;
            if (trade_valid) first = k;
        end
        check("rt_saw_trade", 32'(first > 0), 1);
        reset = 1'b1;
        #1;
        check("rt_tv_immediate", 32'(trade_valid), 0);
        @(negedge clk);
        check("rt_trade_valid", 32'(trade_valid), 0);
        check("rt_trade_price", 32'(trade_price), 0);
        check("rt_trade_count", 32'(trade_count), 0);
        check("rt_busy",        32'(busy), 0);
        check("rt_depths",      32'({bid_depth, ask_depth}), 0);
        order_tick = 1'b0;
        reset = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
